// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Load/store execution block. Accepts one decoded memory access at a time,
// drives a word-wide request/acknowledge bus (splitting misaligned accesses
// into two consecutive word beats) and returns sign/zero-extended load data
// with a one-cycle completion pulse.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cpu_req               start an access (taken only while cpu_ready=1)
//   cpu_memwr             1=store, 0=load
//   cpu_memop[2:0]        000 B, 001 H, 010 W, 100 BU, 101 HU
//   cpu_addr[31:0]        byte address
//   cpu_wdata[31:0]       right-aligned store data
//   cpu_ready             idle, can take cpu_req
//   cpu_done              one-cycle completion pulse
//   cpu_err               with cpu_done: illegal memop or bus timeout
//   cpu_rdata[31:0]       extended load data, held until the next load done
//   bus_req/bus_we        beat request (held until bus_ack) / write beat
//   bus_addr[31:0]        word address
//   bus_wstrb[3:0]        byte lanes on write beats, 0 on read beats
//   bus_wdata[31:0]       lane-aligned store data
//   bus_ack, bus_rdata    beat complete, read word valid with bus_ack
// All outputs are registered.
// ---------------------------------------------------------------------------
module mem_access_unit #(
   parameter int unsigned BUS_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_req,
   input  logic        cpu_memwr,
   input  logic [2:0]  cpu_memop,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_ready,
   output logic        cpu_done,
   output logic        cpu_err,
   output logic [31:0] cpu_rdata,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_wstrb,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT0 = 2'd1,
      BEAT1 = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [31:0] TO_VAL  = BUS_TIMEOUT;
   localparam logic [31:0] TO_LAST = TO_VAL - 32'd1;
   localparam bit          TO_EN   = (TO_VAL != 32'd0);

   // Byte-lane mask of an access, before shifting to its byte offset.
   function automatic logic [3:0] size_mask(input logic [1:0] sz);
      case (sz)
         2'b00:   size_mask = 4'b0001;
         2'b01:   size_mask = 4'b0011;
         2'b10:   size_mask = 4'b1111;
         default: size_mask = 4'b0000;
      endcase
   endfunction

   // Access size in bytes.
   function automatic logic [2:0] size_bytes(input logic [1:0] sz);
      case (sz)
         2'b00:   size_bytes = 3'd1;
         2'b01:   size_bytes = 3'd2;
         default: size_bytes = 3'd4;
      endcase
   endfunction

   // Legal encodings; unsigned variants exist only for loads.
   function automatic logic memop_ok(input logic wr, input logic [2:0] op);
      case (op)
         3'b000, 3'b001, 3'b010: memop_ok = 1'b1;
         3'b100, 3'b101:         memop_ok = ~wr;
         default:                memop_ok = 1'b0;
      endcase
   endfunction

   // Sign/zero extension of the right-aligned load value.
   function automatic logic [31:0] load_extend(input logic [2:0] op, input logic [31:0] v);
      case (op)
         3'b000:  load_extend = {{24{v[7]}}, v[7:0]};
         3'b001:  load_extend = {{16{v[15]}}, v[15:0]};
         3'b100:  load_extend = {24'd0, v[7:0]};
         3'b101:  load_extend = {16'd0, v[15:0]};
         default: load_extend = v;
      endcase
   endfunction

   state_t       state_r, state_s;
   logic         memwr_r, memwr_s;
   logic [2:0]   memop_r, memop_s;
   logic [1:0]   off_r, off_s;
   logic         split_r, split_s;
   logic [7:0]   m8_r, m8_s;
   logic [63:0]  d64_r, d64_s;
   logic [31:0]  lo_r, lo_s;
   logic [31:0]  tcnt_r, tcnt_s;

   logic         cpu_ready_r, cpu_ready_s;
   logic         cpu_done_r, cpu_done_s;
   logic         cpu_err_r, cpu_err_s;
   logic [31:0]  cpu_rdata_r, cpu_rdata_s;
   logic         bus_req_r, bus_req_s;
   logic         bus_we_r, bus_we_s;
   logic [31:0]  bus_addr_r, bus_addr_s;
   logic [3:0]   bus_wstrb_r, bus_wstrb_s;
   logic [31:0]  bus_wdata_r, bus_wdata_s;

   logic [7:0]   req_m8_s;
   logic [63:0]  req_d64_s;
   logic         req_split_s;
   logic [63:0]  rd64_s;
   logic [63:0]  rd_shift_s;
   logic [31:0]  rd_ext_s;
   logic         timeout_s;

   // Lane placement of a new request, computed straight from the cpu inputs.
   assign req_m8_s    = {4'b0000, size_mask(cpu_memop[1:0])} << cpu_addr[1:0];
   assign req_d64_s   = {32'd0, cpu_wdata} << {cpu_addr[1:0], 3'b000};
   assign req_split_s = ({1'b0, cpu_addr[1:0]} + size_bytes(cpu_memop[1:0])) > 3'd4;

   // Load assembly: the word acked now is hi in BEAT1, lo (with hi=0) in BEAT0.
   assign rd64_s     = (state_r == BEAT1) ? {bus_rdata, lo_r} : {32'd0, bus_rdata};
   assign rd_shift_s = rd64_s >> {off_r, 3'b000};
   assign rd_ext_s   = load_extend(memop_r, rd_shift_s[31:0]);

   assign timeout_s  = TO_EN && (tcnt_r == TO_LAST);

   // Next-state and next-output computation.
   always_comb begin
      state_s     = state_r;
      memwr_s     = memwr_r;
      memop_s     = memop_r;
      off_s       = off_r;
      split_s     = split_r;
      m8_s        = m8_r;
      d64_s       = d64_r;
      lo_s        = lo_r;
      tcnt_s      = tcnt_r;
      cpu_done_s  = 1'b0;
      cpu_err_s   = 1'b0;
      cpu_rdata_s = cpu_rdata_r;
      bus_req_s   = bus_req_r;
      bus_we_s    = bus_we_r;
      bus_addr_s  = bus_addr_r;
      bus_wstrb_s = bus_wstrb_r;
      bus_wdata_s = bus_wdata_r;

      case (state_r)
         IDLE: begin
            if (cpu_req) begin
               memwr_s = cpu_memwr;
               memop_s = cpu_memop;
               off_s   = cpu_addr[1:0];
               split_s = req_split_s;
               m8_s    = req_m8_s;
               d64_s   = req_d64_s;
               tcnt_s  = 32'd0;
               if (memop_ok(cpu_memwr, cpu_memop)) begin
                  state_s     = BEAT0;
                  bus_req_s   = 1'b1;
                  bus_we_s    = cpu_memwr;
                  bus_addr_s  = {cpu_addr[31:2], 2'b00};
                  bus_wstrb_s = cpu_memwr ? req_m8_s[3:0] : 4'b0000;
                  bus_wdata_s = cpu_memwr ? req_d64_s[31:0] : 32'd0;
               end else begin
                  state_s    = DONE;
                  cpu_done_s = 1'b1;
                  cpu_err_s  = 1'b1;
               end
            end else begin
               state_s = IDLE;
            end
         end

         BEAT0: begin
            if (bus_ack) begin
               lo_s = bus_rdata;
               if (split_r) begin
                  // Second word; the +4 naturally wraps 0xFFFFFFFC to 0.
                  state_s     = BEAT1;
                  tcnt_s      = 32'd0;
                  bus_addr_s  = bus_addr_r + 32'd4;
                  bus_wstrb_s = memwr_r ? m8_r[7:4] : 4'b0000;
                  bus_wdata_s = memwr_r ? d64_r[63:32] : 32'd0;
               end else begin
                  state_s     = DONE;
                  cpu_done_s  = 1'b1;
                  bus_req_s   = 1'b0;
                  bus_we_s    = 1'b0;
                  bus_wstrb_s = 4'b0000;
                  bus_wdata_s = 32'd0;
                  cpu_rdata_s = memwr_r ? cpu_rdata_r : rd_ext_s;
               end
            end else if (timeout_s) begin
               state_s     = DONE;
               cpu_done_s  = 1'b1;
               cpu_err_s   = 1'b1;
               bus_req_s   = 1'b0;
               bus_we_s    = 1'b0;
               bus_wstrb_s = 4'b0000;
               bus_wdata_s = 32'd0;
            end else begin
               tcnt_s = tcnt_r + 32'd1;
            end
         end

         BEAT1: begin
            if (bus_ack) begin
               state_s     = DONE;
               cpu_done_s  = 1'b1;
               bus_req_s   = 1'b0;
               bus_we_s    = 1'b0;
               bus_wstrb_s = 4'b0000;
               bus_wdata_s = 32'd0;
               cpu_rdata_s = memwr_r ? cpu_rdata_r : rd_ext_s;
            end else if (timeout_s) begin
               // A store has already written its first word; it stays written.
               state_s     = DONE;
               cpu_done_s  = 1'b1;
               cpu_err_s   = 1'b1;
               bus_req_s   = 1'b0;
               bus_we_s    = 1'b0;
               bus_wstrb_s = 4'b0000;
               bus_wdata_s = 32'd0;
            end else begin
               tcnt_s = tcnt_r + 32'd1;
            end
         end

         DONE: begin
            state_s = IDLE;
         end

         default: begin
            state_s   = IDLE;
            bus_req_s = 1'b0;
         end
      endcase

      cpu_ready_s = (state_s == IDLE);
   end

   // State and registered-output update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         memwr_r     <= 1'b0;
         memop_r     <= 3'b000;
         off_r       <= 2'b00;
         split_r     <= 1'b0;
         m8_r        <= 8'h00;
         d64_r       <= 64'd0;
         lo_r        <= 32'd0;
         tcnt_r      <= 32'd0;
         cpu_ready_r <= 1'b1;
         cpu_done_r  <= 1'b0;
         cpu_err_r   <= 1'b0;
         cpu_rdata_r <= 32'd0;
         bus_req_r   <= 1'b0;
         bus_we_r    <= 1'b0;
         bus_addr_r  <= 32'd0;
         bus_wstrb_r <= 4'b0000;
         bus_wdata_r <= 32'd0;
      end else begin
         state_r     <= state_s;
         memwr_r     <= memwr_s;
         memop_r     <= memop_s;
         off_r       <= off_s;
         split_r     <= split_s;
         m8_r        <= m8_s;
         d64_r       <= d64_s;
         lo_r        <= lo_s;
         tcnt_r      <= tcnt_s;
         cpu_ready_r <= cpu_ready_s;
         cpu_done_r  <= cpu_done_s;
         cpu_err_r   <= cpu_err_s;
         cpu_rdata_r <= cpu_rdata_s;
         bus_req_r   <= bus_req_s;
         bus_we_r    <= bus_we_s;
         bus_addr_r  <= bus_addr_s;
         bus_wstrb_r <= bus_wstrb_s;
         bus_wdata_r <= bus_wdata_s;
      end
   end

   assign cpu_ready = cpu_ready_r;
   assign cpu_done  = cpu_done_r;
   assign cpu_err   = cpu_err_r;
   assign cpu_rdata = cpu_rdata_r;
   assign bus_req   = bus_req_r;
   assign bus_we    = bus_we_r;
   assign bus_addr  = bus_addr_r;
   assign bus_wstrb = bus_wstrb_r;
   assign bus_wdata = bus_wdata_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
// Directed bench for mem_access_unit (BUS_TIMEOUT=4). The bus side is driven
// beat by beat from the stimulus process; outputs are sampled on the falling
// edge. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_req;
   logic        cpu_memwr;
   logic [2:0]  cpu_memop;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_ready;
   logic        cpu_done;
   logic        cpu_err;
   logic [31:0] cpu_rdata;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   mem_access_unit #(.BUS_TIMEOUT(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu_req   (cpu_req),
      .cpu_memwr (cpu_memwr),
      .cpu_memop (cpu_memop),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_ready (cpu_ready),
      .cpu_done  (cpu_done),
      .cpu_err   (cpu_err),
      .cpu_rdata (cpu_rdata),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wstrb (bus_wstrb),
      .bus_wdata (bus_wdata),
      .bus_ack   (bus_ack),
      .bus_rdata (bus_rdata)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present one request for one cycle; returns at the falling edge of the
   // first cycle after acceptance.
   task automatic issue(input logic wr, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wd);
      cpu_req   = 1'b1;
      cpu_memwr = wr;
      cpu_memop = op;
      cpu_addr  = addr;
      cpu_wdata = wd;
      @(negedge clk);
      cpu_req   = 1'b0;
   endtask

   // One bus beat: 'waits' cycles without ack, then ack. Bus outputs are
   // checked every cycle of the beat, which also covers their stability.
   task automatic beat(input string tag, input int waits, input logic [31:0] rdata,
                       input logic [31:0] exp_addr, input logic exp_we,
                       input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
      for (int i = 0; i <= waits; i++) begin
         check({tag, ".req"},   {63'd0, bus_req},   64'd1);
         check({tag, ".addr"},  {32'd0, bus_addr},  {32'd0, exp_addr});
         check({tag, ".we"},    {63'd0, bus_we},    {63'd0, exp_we});
         check({tag, ".wstrb"}, {60'd0, bus_wstrb}, {60'd0, exp_strb});
         if (exp_we) begin
            check({tag, ".wdata"}, {32'd0, bus_wdata}, {32'd0, exp_wdata});
         end
         check({tag, ".done"},  {63'd0, cpu_done},  64'd0);
         if (i == waits) begin
            bus_ack   = 1'b1;
            bus_rdata = rdata;
         end
         @(negedge clk);
      end
      bus_ack   = 1'b0;
      bus_rdata = 32'd0;
   endtask

   // Called in the cycle cpu_done is expected; also checks the return to idle.
   task automatic finish_check(input string tag, input logic exp_err, input logic [31:0] exp_rdata);
      check({tag, ".done"},  {63'd0, cpu_done},  64'd1);
      check({tag, ".err"},   {63'd0, cpu_err},   {63'd0, exp_err});
      check({tag, ".rdata"}, {32'd0, cpu_rdata}, {32'd0, exp_rdata});
      check({tag, ".busreq"},{63'd0, bus_req},   64'd0);
      @(negedge clk);
      check({tag, ".pulse"}, {63'd0, cpu_done},  64'd0);
      check({tag, ".erridle"}, {63'd0, cpu_err}, 64'd0);
      check({tag, ".ready"}, {63'd0, cpu_ready}, 64'd1);
   endtask

   // Directed stimulus.
   initial begin
      rst_n     = 1'b0;
      cpu_req   = 1'b0;
      cpu_memwr = 1'b0;
      cpu_memop = 3'b000;
      cpu_addr  = 32'd0;
      cpu_wdata = 32'd0;
      bus_ack   = 1'b0;
      bus_rdata = 32'd0;
      repeat (2) @(negedge clk);
      check("rst.ready", {63'd0, cpu_ready}, 64'd1);
      check("rst.done",  {63'd0, cpu_done},  64'd0);
      check("rst.err",   {63'd0, cpu_err},   64'd0);
      check("rst.rdata", {32'd0, cpu_rdata}, 64'd0);
      check("rst.req",   {63'd0, bus_req},   64'd0);
      check("rst.wstrb", {60'd0, bus_wstrb}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Aligned word load: done two cycles after acceptance.
      issue(1'b0, 3'b010, 32'h0000_0100, 32'd0);
      check("lw.busy", {63'd0, cpu_ready}, 64'd0);
      beat("lw", 0, 32'hDEAD_BEEF, 32'h0000_0100, 1'b0, 4'b0000, 32'd0);
      finish_check("lw", 1'b0, 32'hDEAD_BEEF);

      // Byte/half loads at the top of a word: single beat, extension.
      issue(1'b0, 3'b000, 32'h0000_0203, 32'd0);
      beat("lb", 0, 32'h80AA_BBCC, 32'h0000_0200, 1'b0, 4'b0000, 32'd0);
      finish_check("lb", 1'b0, 32'hFFFF_FF80);
      issue(1'b0, 3'b100, 32'h0000_0203, 32'd0);
      beat("lbu", 0, 32'h80AA_BBCC, 32'h0000_0200, 1'b0, 4'b0000, 32'd0);
      finish_check("lbu", 1'b0, 32'h0000_0080);
      issue(1'b0, 3'b001, 32'h0000_0202, 32'd0);
      beat("lh", 0, 32'h80AA_BBCC, 32'h0000_0200, 1'b0, 4'b0000, 32'd0);
      finish_check("lh", 1'b0, 32'hFFFF_80AA);
      issue(1'b0, 3'b101, 32'h0000_0202, 32'd0);
      beat("lhu", 0, 32'h80AA_BBCC, 32'h0000_0200, 1'b0, 4'b0000, 32'd0);
      finish_check("lhu", 1'b0, 32'h0000_80AA);

      // Misaligned store: two beats, bus_req continuous; rdata untouched.
      issue(1'b1, 3'b010, 32'h0000_0302, 32'h1122_3344);
      beat("sw0", 0, 32'd0, 32'h0000_0300, 1'b1, 4'b1100, 32'h3344_0000);
      beat("sw1", 0, 32'd0, 32'h0000_0304, 1'b1, 4'b0011, 32'h0000_1122);
      finish_check("sw", 1'b0, 32'h0000_80AA);

      // Misaligned half at the top of memory: address wraps, one wait cycle.
      issue(1'b0, 3'b001, 32'hFFFF_FFFF, 32'd0);
      beat("lhw0", 0, 32'hAB00_0000, 32'hFFFF_FFFC, 1'b0, 4'b0000, 32'd0);
      beat("lhw1", 1, 32'h0000_00CD, 32'h0000_0000, 1'b0, 4'b0000, 32'd0);
      finish_check("lhw", 1'b0, 32'hFFFF_CDAB);

      // Illegal memop and signed-only store encodings: no bus activity.
      issue(1'b0, 3'b011, 32'h0000_0040, 32'd0);
      finish_check("bad011", 1'b1, 32'hFFFF_CDAB);
      issue(1'b1, 3'b100, 32'h0000_0044, 32'h5555_5555);
      finish_check("badst", 1'b1, 32'hFFFF_CDAB);

      // cpu_req held during BEAT0 of an access must be ignored.
      issue(1'b0, 3'b010, 32'h0000_0400, 32'd0);
      cpu_req   = 1'b1;
      cpu_memop = 3'b011;
      cpu_addr  = 32'h0000_0800;
      beat("ign", 1, 32'h1234_5678, 32'h0000_0400, 1'b0, 4'b0000, 32'd0);
      cpu_req   = 1'b0;
      finish_check("ign", 1'b0, 32'h1234_5678);
      check("ign.quiet.req",  {63'd0, bus_req},  64'd0);
      check("ign.quiet.done", {63'd0, cpu_done}, 64'd0);

      // Bus timeout after 4 cycles without ack.
      issue(1'b0, 3'b010, 32'h0000_0500, 32'd0);
      for (int i = 0; i < 4; i++) begin
         check("to.req", {63'd0, bus_req}, 64'd1);
         @(negedge clk);
      end
      finish_check("to", 1'b1, 32'h1234_5678);

      // Reset in the middle of a beat: bus_req drops at once, no done.
      issue(1'b0, 3'b010, 32'h0000_0600, 32'd0);
      check("rb.req", {63'd0, bus_req}, 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rb.dropreq", {63'd0, bus_req},   64'd0);
      check("rb.ready",   {63'd0, cpu_ready}, 64'd1);
      check("rb.rdata",   {32'd0, cpu_rdata}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("rb.nodone", {63'd0, cpu_done}, 64'd0);
         check("rb.noreq",  {63'd0, bus_req},  64'd0);
         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store execution block on the memory side of the control decoder.
- Consumes the decoded memory controls (memwr, memop) plus the ALU address and rs2 data.
- Drives a word-wide request/acknowledge data bus. Splits misaligned accesses into two word beats.
- Returns sign- or zero-extended load data to the register write-back path with a one-cycle done pulse.

Parameters:
- BUS_TIMEOUT, 255, cycles to wait for bus_ack per beat before aborting with error; 0 disables the timeout.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- cpu_req  input  1  start a load/store; accepted only when cpu_ready=1
- cpu_memwr  input  1  1=store, 0=load
- cpu_memop  input  3  access type, same encoding as func3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- cpu_addr  input  32  byte address
- cpu_wdata  input  32  store data, right-aligned
- cpu_ready  output  1  block idle, can accept cpu_req
- cpu_done  output  1  one-cycle pulse, access complete
- cpu_err  output  1  valid with cpu_done: bad memop or bus timeout
- cpu_rdata  output  32  extended load data; held until next cpu_done
- bus_req  output  1  bus request, held until acknowledged
- bus_we  output  1  write beat
- bus_addr  output  32  word address, bits [1:0] always 0
- bus_wstrb  output  4  byte-lane enables for write beats; 0 on read beats
- bus_wdata  output  32  lane-aligned write data
- bus_ack  input  1  beat complete; bus_rdata valid in the same cycle
- bus_rdata  input  32  read word

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
  - Reset forces state IDLE.
  - All outputs reset to 0 except cpu_ready=1.
  - Reset during a beat drops bus_req immediately. The access is lost and no cpu_done is issued.
- States: IDLE, BEAT0, BEAT1, DONE.
- IDLE:
  - cpu_ready=1.
  - On cpu_req=1, latch memwr, memop, addr, wdata. Set off=addr[1:0] and size=1/2/4 from memop[1:0].
  - cpu_req while not in IDLE is ignored.
- Bad memop (011, 110, 111, or a store with memop[2]=1):
  - IDLE -> DONE with no bus activity.
  - cpu_err=1; cpu_rdata unchanged.
- Split rule: split=1 when off+size>4.
- IDLE -> BEAT0:
  - Drive bus_req=1, bus_addr={addr[31:2],2'b00}, bus_we=memwr.
- BEAT0 on bus_ack:
  - Capture bus_rdata into lo.
  - If split, go to BEAT1 in the next cycle. bus_req stays 1 and bus_addr becomes the previous word address +4; 0xFFFFFFFC wraps to 0x00000000.
  - If not split, go to DONE.
- BEAT1 on bus_ack: capture hi, go to DONE.
- bus_req drops in the cycle after the final ack.
- Bus outputs are stable while bus_req=1 and bus_ack=0.
- Write lanes:
  - m8 = ({4'b0, size mask} << off), where size mask is 0001/0011/1111; d64 = {32'b0, wdata} << (8*off).
  - BEAT0: wstrb=m8[3:0], wdata=d64[31:0].
  - BEAT1: wstrb=m8[7:4], wdata=d64[63:32].
- Read assembly:
  - v = ({hi,lo} >> (8*off)); hi=0 when not split.
  - B and H sign-extend from bit 7 and bit 15 respectively; BU and HU zero-extend; W passes v[31:0].
- DONE:
  - cpu_done=1 for exactly one cycle; cpu_rdata updates on loads only.
  - Next cycle goes to IDLE, so cpu_ready=1 again. Minimum turnaround from cpu_req to the next accept is latency + 1 cycle.
- Latency: an aligned access with ack in the first bus cycle gives cpu_done 2 cycles after cpu_req acceptance. Each wait cycle or extra beat adds 1.
- Timeout:
  - A per-beat counter resets on entering each beat.
  - If BUS_TIMEOUT cycles pass with no ack (BUS_TIMEOUT != 0): drop bus_req, go to DONE with cpu_err=1.
  - Stores are partially performed if the timeout hits in BEAT1.
- Errors: cpu_err=0 on all successful completions. cpu_err is meaningful only when cpu_done=1 and is otherwise 0.

Test Plan:
1. LW addr 0x100, bus_ack one cycle after bus_req, bus_rdata 0xDEADBEEF -> one beat, bus_addr 0x100, wstrb 0, cpu_done 2 cycles after accept, cpu_rdata 0xDEADBEEF, cpu_err 0.
2. LB / LBU addr 0x203, rdata 0x80AABBCC -> LB gives 0xFFFFFF80, LBU gives 0x00000080; single beat each.
3. SW addr 0x302, wdata 0x11223344 -> beat0: addr 0x300, wstrb 1100, wdata 0x33440000; beat1: addr 0x304, wstrb 0011, wdata 0x00001122; bus_req continuous across beats; then cpu_done.
4. LH addr 0xFFFFFFFF, beats return 0xAB000000 then 0x000000CD -> second bus_addr 0x00000000, cpu_rdata 0xFFFFCDAB.
5. memop 011 -> no bus_req ever; cpu_done with cpu_err=1 one cycle after accept. cpu_req pulsed during BEAT0 of a prior access -> ignored.
6. BUS_TIMEOUT=4 with bus_ack held 0 -> bus_req drops after 4 cycles, cpu_done with cpu_err=1. Then rst_n asserted mid-beat on a new access -> bus_req=0 immediately, cpu_ready=1, no cpu_done.
